// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared constants for the seven-segment display slice.
//   NIBBLE_W : width of one hex digit
//   SEG_W    : number of segment lines a..g
//   FONT     : hex-to-segment table, entry n drives digit n (bit0 = a .. bit6 = g)
package seg7_pkg;

    localparam int NIBBLE_W = 4;
    localparam int SEG_W    = 7;

    // Listed from entry 15 down to entry 0.
    localparam logic [15:0][SEG_W-1:0] FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_hex_font.sv
// seg7_hex_font -- combinational hex nibble to seven-segment pattern.
//   nibble : input  [3:0] hex digit
//   seg    : output [6:0] segment pattern, active-high, bit0 = a
module seg7_hex_font
    import seg7_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [SEG_W-1:0]    seg
);

    assign seg = FONT[nibble];

endmodule

// File: rtl/seg7_mux.sv
// seg7_mux -- time-multiplexed driver for a common-anode/cathode hex display.
// Each digit owns a slot of SCAN_DIV clocks; the first DEAD_CYCLES of a slot
// are blanked to stop ghosting. New data is staged by load and only copied to
// the displayed (shadow) register at a frame boundary, so a frame never tears.
// Optional: define SEG7_MUX_LZB_EN for leading-zero blanking.
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   value, dp  : hex nibbles and decimal points, digit 0 least significant
//   load       : one-cycle capture strobe for value/dp
//   pending    : staged data waiting for the next frame boundary
//   seg,dp_out : segment drives, active-high (registered)
//   com        : digit commons, active level set by COM_ACTIVE_LOW (registered)
//   frame_tick : one-cycle pulse as digit 0 starts a new frame
module seg7_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 27000,
    parameter int DEAD_CYCLES    = 16,
    parameter int COM_ACTIVE_LOW = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]          dp,
    input  logic                           load,
    output logic                           pending,
    output logic [SEG_W-1:0]               seg,
    output logic                           dp_out,
    output logic [NUM_DIGITS-1:0]          com,
    output logic                           frame_tick
);

    localparam int   PRE_W  = $clog2(SCAN_DIV);
    localparam int   IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic COM_ON = (COM_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

    logic [PRE_W-1:0]                    pre, pre_nxt;
    logic [IDX_W-1:0]                    idx, idx_nxt;
    logic [NUM_DIGITS-1:0][NIBBLE_W-1:0] stage_val, shadow_val, shadow_val_nxt;
    logic [NUM_DIGITS-1:0]               stage_dp, shadow_dp, shadow_dp_nxt;
    logic                                pre_wrap, frame_wrap, slot_on, blank_digit, dp_sel;
    logic [NIBBLE_W-1:0]                 nib_sel;
    logic [SEG_W-1:0]                    font_seg;
    logic [NUM_DIGITS-1:0]               com_nxt;
`ifdef SEG7_MUX_LZB_EN
    logic [IDX_W-1:0]                    msd;
`endif

    // Outputs are registered from the *next* scan position and shadow contents,
    // so what appears on the pins always matches the current prescaler/index.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned
        // (an unassigned path in combinational logic infers a latch).
        pre_wrap   = (pre == PRE_W'(SCAN_DIV - 1));
        frame_wrap = pre_wrap && (idx == IDX_W'(NUM_DIGITS - 1));
        pre_nxt    = pre_wrap ? '0 : pre + 1'b1;
        idx_nxt    = idx;
        if (pre_wrap)
            idx_nxt = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;

        shadow_val_nxt = (frame_wrap && pending) ? stage_val : shadow_val;
        shadow_dp_nxt  = (frame_wrap && pending) ? stage_dp  : shadow_dp;

        slot_on = (pre_nxt >= PRE_W'(DEAD_CYCLES));
        nib_sel = '0;
        dp_sel  = 1'b0;
        com_nxt = {NUM_DIGITS{~COM_ON}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nxt == IDX_W'(i)) begin
                nib_sel = shadow_val_nxt[i];
                dp_sel  = shadow_dp_nxt[i];
                if (slot_on)
                    com_nxt[i] = COM_ON;
            end
        end

`ifdef SEG7_MUX_LZB_EN
        // Highest nonzero digit; stays 0 for an all-zero value so digit 0 always shows.
        msd = '0;
        for (int i = 1; i < NUM_DIGITS; i++)
            if (shadow_val_nxt[i] != '0)
                msd = IDX_W'(i);
        blank_digit = (idx_nxt > msd);
`else
        blank_digit = 1'b0;
`endif
    end

    seg7_hex_font u_font (
        .nibble (nib_sel),
        .seg    (font_seg)
    );

    // NOTE: staging and shadow are plain flops rather than a RAM, so they take the
    // reset like any other state and a held load during reset is simply lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre        <= '0;
            idx        <= '0;
            stage_val  <= '0;
            stage_dp   <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
            frame_tick <= 1'b0;
            seg        <= '0;
            dp_out     <= 1'b0;
            com        <= {NUM_DIGITS{~COM_ON}};
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            pre        <= pre_nxt;
            idx        <= idx_nxt;
            shadow_val <= shadow_val_nxt;
            shadow_dp  <= shadow_dp_nxt;
            frame_tick <= frame_wrap;
            // A load on the wrap edge wins: shadow takes the old staging, the
            // new data waits one more frame with pending still set.
            if (load) begin
                stage_val <= value;
                stage_dp  <= dp;
                pending   <= 1'b1;
            end else if (frame_wrap) begin
                pending   <= 1'b0;
            end
            seg    <= (slot_on && !blank_digit) ? font_seg : '0;
            dp_out <= slot_on && dp_sel;
            com    <= com_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_mux.sv
// tb_seg7_mux -- directed self-checking bench for seg7_mux
// (NUM_DIGITS=4, SCAN_DIV=8, DEAD_CYCLES=2; one active-low and one active-high instance).
module tb_seg7_mux;

    logic        clk, rst;
    logic [15:0] value, value_h;
    logic [3:0]  dp, dp_h;
    logic        load, load_h;
    logic        pending, pending_h, dp_out, dp_out_h, frame_tick, frame_tick_h;
    logic [6:0]  seg, seg_h;
    logic [3:0]  com, com_h;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

`ifdef SEG7_MUX_LZB_EN
    localparam logic [6:0] ZB = 7'h00;   // leading zero digit
`else
    localparam logic [6:0] ZB = 7'h3F;
`endif

    seg7_mux #(.NUM_DIGITS(4), .SCAN_DIV(8), .DEAD_CYCLES(2), .COM_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load), .pending(pending),
        .seg(seg), .dp_out(dp_out), .com(com), .frame_tick(frame_tick)
    );

    seg7_mux #(.NUM_DIGITS(4), .SCAN_DIV(8), .DEAD_CYCLES(2), .COM_ACTIVE_LOW(0)) dut_hi (
        .clk(clk), .rst(rst), .value(value_h), .dp(dp_h), .load(load_h), .pending(pending_h),
        .seg(seg_h), .dp_out(dp_out_h), .com(com_h), .frame_tick(frame_tick_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_main(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        step(1);
        load  = 1'b0;
    endtask

    // Advances at least one cycle, stops on the negedge where frame_tick is high.
    task automatic wait_frame(input bit hi);
        bit seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            step(1);
            seen = hi ? frame_tick_h : frame_tick;
        end
        if (!seen)
            check("frame_tick_timeout", hi ? frame_tick_h : frame_tick, 1);
    endtask

    // Called on cycle 0 of a frame; checks all 32 cycles, returns on cycle 0 of the next.
    // eseg packs {digit3, digit2, digit1, digit0} segment patterns.
    task automatic check_frame(input string tag, input bit hi, input logic [27:0] eseg,
                               input logic [3:0] edp);
        for (int c = 0; c < 32; c++) begin
            int         d  = c / 8;
            bit         on = (c % 8) >= 2;
            logic [3:0] ecom;
            logic [6:0] es;
            logic       ed;
            logic [12:0] obs;
            if (hi) ecom = on ? (4'b0001 << d) : 4'b0000;
            else    ecom = on ? ~(4'b0001 << d) : 4'b1111;
            es  = on ? eseg[d*7 +: 7] : 7'h00;
            ed  = on && edp[d];
            obs = hi ? {frame_tick_h, com_h, seg_h, dp_out_h} : {frame_tick, com, seg, dp_out};
            check($sformatf("%s c%0d {tick,com,seg,dp}", tag, c), obs, {(c == 0), ecom, es, ed});
            step(1);
        end
    endtask

    logic [15:0] sweep_v [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
    logic [27:0] sweep_s [4] = '{{7'h4F, 7'h5B, 7'h06, 7'h3F},
                                 {7'h07, 7'h7D, 7'h6D, 7'h66},
                                 {7'h7C, 7'h77, 7'h6F, 7'h7F},
                                 {7'h71, 7'h79, 7'h5E, 7'h39}};

    initial begin
        rst = 1'b1; load = 1'b0; value = '0; dp = '0;
        load_h = 1'b0; value_h = '0; dp_h = '0;

        // Reset state
        step(2);
        check("rst com", com, 4'b1111);
        check("rst seg", seg, 7'h00);
        check("rst dp_out", dp_out, 1'b0);
        check("rst pending", pending, 1'b0);
        check("rst frame_tick", frame_tick, 1'b0);
        check("rst com_h", com_h, 4'b0000);

        // Load during reset is discarded; scanning starts with digit 0 dead time
        value = 16'h9999; load = 1'b1;
        step(1);
        load = 1'b0; rst = 1'b0;
        check("release pre0 com", com, 4'b1111);
        step(1);
        check("release pre1 com", com, 4'b1111);
        step(1);
        check("release pre2 com", com, 4'b1110);
        check("release pre2 seg", seg, 7'h3F);
        check("reset load discarded", pending, 1'b0);

        // 1234: pending until frame boundary, then displayed
        load_main(16'h1234);
        check("1234 pending set", pending, 1'b1);
        wait_frame(0);
        check("1234 pending clear", pending, 1'b0);
        check_frame("1234", 0, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000);

        // Font sweep
        for (int k = 0; k < 4; k++) begin
            load_main(sweep_v[k]);
            wait_frame(0);
            check_frame($sformatf("sweep%0h", sweep_v[k]), 0, sweep_s[k], 4'b0000);
        end

        // Last load wins, old data held until the boundary
        step(10);
        load_main(16'hABCD);
        step(1);
        load_main(16'h0001);
        check("double load pending", pending, 1'b1);
        step(15);   // cycle 28: digit 3 active, still FEDC
        check("tear-free digit3", seg, 7'h71);
        wait_frame(0);
        check("0001 pending clear", pending, 1'b0);
        check_frame("0001", 0, {ZB, ZB, ZB, 7'h06}, 4'b0000);

        // Load exactly on the frame wrap edge waits a whole frame
        step(31);
        value = 16'h5A5A; load = 1'b1;
        step(1);
        load = 1'b0;
        check("wrap load tick", frame_tick, 1'b1);
        check("wrap load pending", pending, 1'b1);
        step(2);
        check("wrap load old digit0", seg, 7'h06);
        wait_frame(0);
        check("5A5A pending clear", pending, 1'b0);
        check_frame("5A5A", 0, {7'h6D, 7'h77, 7'h6D, 7'h77}, 4'b0000);

        // Leading zeros
        load_main(16'h0050);
        wait_frame(0);
        check_frame("0050", 0, {ZB, ZB, 7'h6D, 7'h3F}, 4'b0000);
        load_main(16'h0000);
        wait_frame(0);
        check_frame("0000", 0, {ZB, ZB, ZB, 7'h3F}, 4'b0000);

        // Asynchronous reset mid-scan (index 2, prescaler 5)
        load_main(16'h8888);
        step(20);
        check("pre-reset com", com, 4'b1011);
        check("pre-reset pending", pending, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async rst com", com, 4'b1111);
        check("async rst seg", seg, 7'h00);
        check("async rst pending", pending, 1'b0);
        @(negedge clk);
        value = 16'h7777; load = 1'b1;
        step(1);
        load = 1'b0;
        step(1);
        rst = 1'b0;
        check("re-release com", com, 4'b1111);
        step(2);
        check("re-release digit0 com", com, 4'b1110);
        check("re-release digit0 seg", seg, 7'h3F);
        check("re-release pending", pending, 1'b0);

        // Active-high commons and a decimal point on digit 2
        value_h = 16'h0321; dp_h = 4'b0100; load_h = 1'b1;
        step(1);
        load_h = 1'b0;
        check("hi pending", pending_h, 1'b1);
        wait_frame(1);
        check_frame("hi0321", 1, {ZB, 7'h4F, 7'h5B, 7'h06}, 4'b0100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
